mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer that shares the single `memory_controller` between the instruction cache and the data cache. It accepts one outstanding block request per port and grants the memory interface round-robin. It issues exactly one start pulse per transaction and routes the returned 512-bit block back to the requester. A watchdog terminates any transaction that never completes. It sits in `top` between the two caches and `memory_controller`.

## Interface
- `BLOCKSZ`, 512: cache block width in bits.
- `WORDSZ`, 64: address width.
- `TIMEOUT`, 1024: maximum cycles in WAIT before abort; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ic_req`  in  1  icache request, level; held until `ic_valid` is seen.
- `ic_addr`  in  WORDSZ  icache fetch address; stable while `ic_req` is high.
- `ic_data`  out  BLOCKSZ  block returned to icache.
- `ic_valid`  out  1  one-cycle pulse: `ic_data` is valid.
- `ic_err`  out  1  one-cycle pulse together with `ic_valid` on timeout.
- `dc_req`  in  1  dcache request, level.
- `dc_wr`  in  1  1 = block write, 0 = block read.
- `dc_addr`  in  WORDSZ  dcache address.
- `dc_wdata`  in  BLOCKSZ  write block.
- `dc_rdata`  out  BLOCKSZ  block returned to dcache.
- `dc_valid`  out  1  one-cycle completion pulse; also fires for writes.
- `dc_err`  out  1  timeout flag, pulsed with `dc_valid`.
- `mem_addr`  out  WORDSZ  to `memory_controller.in_address`.
- `mem_start_req`  out  1  one-cycle start pulse.
- `mem_wr_en`  out  1  write qualifier.
- `mem_wdata`  out  BLOCKSZ  write block.
- `mem_data_in`  in  BLOCKSZ  from `memory_controller.data_out`.
- `mem_data_valid`  in  1  from `memory_controller.data_valid`; single-cycle pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port opposite `last_grant`.
  - On grant, latch the granted port id, the address with bits [5:0] forced to 0, `wr` (forced 0 for icache) and `wdata`. Go to ISSUE.
- **ISSUE**
  - `mem_start_req` = 1 for exactly this cycle.
  - Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `mem_data_valid`: for a read, capture `mem_data_in` into the granted port's data register. Go to DONE.
  - If the counter reaches TIMEOUT−1 without `mem_data_valid`: set err. Go to DONE.
- **DONE**
  - Granted port's valid = 1; err = 1 only on timeout.
  - Set `last_grant` = granted port. Go to IDLE.
  - Request inputs are ignored in DONE.
- `mem_addr`, `mem_wr_en` and `mem_wdata` come from the latched registers. They hold stable from ISSUE through DONE and keep their last value in IDLE.
- The ungranted port's request stays pending and is never dropped.
- `ic_data` and `dc_rdata` hold their value until the next read completion on that port.
- A write completion does not modify `dc_rdata`.
- `mem_data_valid` is ignored outside WAIT. A late pulse after a timeout is discarded.

## Timing
- Reset (`rst` = 0), asynchronously:
  - state = IDLE, `last_grant` = dcache, so icache wins the first tie.
  - Counter = 0.
  - All outputs = 0: `mem_*`, `ic_data`, `dc_rdata`, valid, err and `busy`.
- Reset mid-transaction aborts it; no valid pulse is produced for it.
- Request sampled high in cycle N (state IDLE):
  - `mem_start_req` is high in cycle N+1.
  - `busy` is high from N+1.
- `mem_data_valid` in cycle M (state WAIT):
  - Port valid is high in cycle M+1; the arbiter is in IDLE in cycle M+2.
  - Minimum request-to-valid latency: 3 cycles plus memory latency.
- Requesters must drop `req` in the cycle after valid. A requester may reassert `req` from M+2.
- Back-to-back requests: the next `mem_start_req` is no earlier than M+3.
- Under constant contention, grants strictly alternate icache/dcache.
- Timeout: `mem_start_req` in cycle S with no `mem_data_valid` gives valid + err in cycle S+TIMEOUT+1.

## Test plan
- Reset then `ic_req` with `ic_addr`=0x1000_0024 → one `mem_start_req` pulse with `mem_addr`=0x1000_0000 and `mem_wr_en`=0. Memory returns pattern A after 5 cycles → `ic_valid` pulses once with `ic_data`=A; `dc_valid` stays 0.
- `ic_req` and `dc_req` (read, 0x2000_0040) rise in the same cycle right after reset → icache served first, then dcache. Hold both requests asserted across 4 transactions → grant order I, D, I, D.
- `dc_req`, `dc_wr`=1, `dc_wdata`=B, `dc_addr`=0x3000_0000 → `mem_wr_en`=1 and `mem_wdata`=B held through WAIT. `dc_valid` pulses; `dc_rdata` is unchanged from its prior value.
- Memory never answers with TIMEOUT=16 → `ic_valid` and `ic_err` pulse together in cycle S+17. A later stray `mem_data_valid` produces no output. The next request is served normally.
- `rst` = 0 asserted in WAIT → all outputs 0 immediately, state IDLE. A new request after release gets `mem_start_req` 1 cycle later.
- `mem_data_valid` pulsed while in IDLE → no valid, no state change, `busy` stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_controller between icache and dcache.
// One outstanding block transaction at a time, with a watchdog on the memory response.
module mem_arbiter #(
    parameter int unsigned BLOCKSZ = 512,
    parameter int unsigned WORDSZ  = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ic_req,
    input  logic [WORDSZ-1:0]  ic_addr,
    output logic [BLOCKSZ-1:0] ic_data,
    output logic               ic_valid,
    output logic               ic_err,
    input  logic               dc_req,
    input  logic               dc_wr,
    input  logic [WORDSZ-1:0]  dc_addr,
    input  logic [BLOCKSZ-1:0] dc_wdata,
    output logic [BLOCKSZ-1:0] dc_rdata,
    output logic               dc_valid,
    output logic               dc_err,
    output logic [WORDSZ-1:0]  mem_addr,
    output logic               mem_start_req,
    output logic               mem_wr_en,
    output logic [BLOCKSZ-1:0] mem_wdata,
    input  logic [BLOCKSZ-1:0] mem_data_in,
    input  logic               mem_data_valid,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [WORDSZ-1:0] AddrMask = {{(WORDSZ - 6){1'b1}}, 6'b0};
    localparam logic PortIc = 1'b0;
    localparam logic PortDc = 1'b1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q;
    logic               port_q;
    logic [WORDSZ-1:0]  addr_q;
    logic               wr_q;
    logic [BLOCKSZ-1:0] wdata_q;
    logic [CntW-1:0]    cnt_q;
    logic               err_q;
    logic [BLOCKSZ-1:0] ic_data_q;
    logic [BLOCKSZ-1:0] dc_rdata_q;
    logic               grant_ic;
    logic               grant_dc;
    logic               cnt_last;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_ic = ic_req && (!dc_req || (last_grant_q == PortDc));
        grant_dc = dc_req && !grant_ic;
        cnt_last = (cnt_q == CntLast);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ic_req || dc_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (mem_data_valid || cnt_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_start_req = (state_q == StIssue);
        busy          = (state_q != StIdle);
        ic_valid      = (state_q == StDone) && (port_q == PortIc);
        dc_valid      = (state_q == StDone) && (port_q == PortDc);
        ic_err        = ic_valid && err_q;
        dc_err        = dc_valid && err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PortDc;
            port_q       <= PortIc;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            ic_data_q    <= '0;
            dc_rdata_q   <= '0;
        end else begin
            if ((state_q == StIdle) && (grant_ic || grant_dc)) begin
                port_q  <= grant_dc;
                addr_q  <= (grant_dc ? dc_addr : ic_addr) & AddrMask;
                wr_q    <= grant_dc && dc_wr;
                wdata_q <= grant_dc ? dc_wdata : wdata_q;
            end
            if (state_q == StIssue) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end
            if (state_q == StWait) begin
                cnt_q <= cnt_q + 1'b1;
                if (!mem_data_valid && cnt_last) begin
                    err_q <= 1'b1;
                end
                // Write completions leave dc_rdata untouched.
                if (mem_data_valid && !wr_q) begin
                    if (port_q == PortIc) begin
                        ic_data_q <= mem_data_in;
                    end else begin
                        dc_rdata_q <= mem_data_in;
                    end
                end
            end
            if (state_q == StDone) begin
                last_grant_q <= port_q;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wr_en = wr_q;
    assign mem_wdata = wdata_q;
    assign ic_data   = ic_data_q;
    assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, reads, arbitration, writes, watchdog, stray responses.
module tb_mem_arbiter;

    localparam int unsigned BLOCKSZ = 512;
    localparam int unsigned WORDSZ  = 64;
    localparam int unsigned TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ic_req = 1'b0;
    logic [WORDSZ-1:0]  ic_addr = '0;
    logic [BLOCKSZ-1:0] ic_data;
    logic               ic_valid;
    logic               ic_err;
    logic               dc_req = 1'b0;
    logic               dc_wr = 1'b0;
    logic [WORDSZ-1:0]  dc_addr = '0;
    logic [BLOCKSZ-1:0] dc_wdata = '0;
    logic [BLOCKSZ-1:0] dc_rdata;
    logic               dc_valid;
    logic               dc_err;
    logic [WORDSZ-1:0]  mem_addr;
    logic               mem_start_req;
    logic               mem_wr_en;
    logic [BLOCKSZ-1:0] mem_wdata;
    logic [BLOCKSZ-1:0] mem_data_in = '0;
    logic               mem_data_valid = 1'b0;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int ic_vcnt = 0;
    int dc_vcnt = 0;
    int start_cnt = 0;
    logic [BLOCKSZ-1:0] exp_ic = '0;
    logic [BLOCKSZ-1:0] exp_dc = '0;

    mem_arbiter #(
        .BLOCKSZ(BLOCKSZ),
        .WORDSZ (WORDSZ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_data       (ic_data),
        .ic_valid      (ic_valid),
        .ic_err        (ic_err),
        .dc_req        (dc_req),
        .dc_wr         (dc_wr),
        .dc_addr       (dc_addr),
        .dc_wdata      (dc_wdata),
        .dc_rdata      (dc_rdata),
        .dc_valid      (dc_valid),
        .dc_err        (dc_err),
        .mem_addr      (mem_addr),
        .mem_start_req (mem_start_req),
        .mem_wr_en     (mem_wr_en),
        .mem_wdata     (mem_wdata),
        .mem_data_in   (mem_data_in),
        .mem_data_valid(mem_data_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ic_valid) ic_vcnt++;
        if (dc_valid) dc_vcnt++;
        if (mem_start_req) start_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ic_req = 1'b0;
        dc_req = 1'b0;
        dc_wr = 1'b0;
        mem_data_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        exp_ic = '0;
        exp_dc = '0;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        do begin
            step();
            n++;
        end while (mem_start_req !== 1'b1 && n < 20);
        ok = (mem_start_req === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_addr !== '0 || mem_start_req !== 1'b0 || mem_wr_en !== 1'b0 || mem_wdata !== '0 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem addr=%h start=%0b wr=%0b busy=%0b, want all 0",
                     mem_addr, mem_start_req, mem_wr_en, busy);
        end
        checks++;
        if (ic_data !== '0 || dc_rdata !== '0 || ic_valid !== 1'b0 || dc_valid !== 1'b0 ||
            ic_err !== 1'b0 || dc_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ports iv=%0b dv=%0b ie=%0b de=%0b, want all 0",
                     ic_valid, dc_valid, ic_err, dc_err);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || mem_start_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%0b start=%0b, want 0 0", busy, mem_start_req);
        end
    endtask

    task automatic test_ic_read();
        logic [BLOCKSZ-1:0] pa = {16{32'hAAAA_0001}};
        int s0, i0, d0;
        do_reset();
        s0 = start_cnt; i0 = ic_vcnt; d0 = dc_vcnt;
        ic_addr = 64'h1000_0024;
        ic_req = 1'b1;
        step();
        checks++;
        if (mem_start_req !== 1'b1 || mem_addr !== 64'h1000_0000 || mem_wr_en !== 1'b0 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL ic_issue start=%0b addr=%h wr=%0b busy=%0b, want 1 1000_0000 0 1",
                     mem_start_req, mem_addr, mem_wr_en, busy);
        end
        step();
        checks++;
        if (mem_start_req !== 1'b0) begin
            errors++;
            $display("FAIL ic_start_pulse start=%0b in WAIT, want 0", mem_start_req);
        end
        repeat (4) step();
        mem_data_in = pa;
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        ic_req = 1'b0;
        checks++;
        if (ic_valid !== 1'b1 || ic_err !== 1'b0 || dc_valid !== 1'b0 || ic_data !== pa) begin
            errors++;
            $display("FAIL ic_done iv=%0b ie=%0b dv=%0b data=%h, want 1 0 0 %h",
                     ic_valid, ic_err, dc_valid, ic_data, pa);
        end
        exp_ic = pa;
        step();
        checks++;
        if (ic_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ic_idle iv=%0b busy=%0b, want 0 0", ic_valid, busy);
        end
        checks++;
        if (start_cnt - s0 != 1 || ic_vcnt - i0 != 1 || dc_vcnt - d0 != 0) begin
            errors++;
            $display("FAIL ic_counts starts=%0d ivalid=%0d dvalid=%0d, want 1 1 0",
                     start_cnt - s0, ic_vcnt - i0, dc_vcnt - d0);
        end
    endtask

    task automatic test_contention();
        logic [BLOCKSZ-1:0] pat;
        logic [WORDSZ-1:0] want_addr;
        bit ok;
        do_reset();
        ic_addr = 64'h1000_0024;
        dc_addr = 64'h2000_0040;
        dc_wr = 1'b0;
        ic_req = 1'b1;
        dc_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pat = {16{32'hC0DE_0000 + 32'(k)}};
            want_addr = (k % 2 == 0) ? 64'h1000_0000 : 64'h2000_0040;
            wait_start(ok);
            checks++;
            if (!ok || mem_addr !== want_addr || mem_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL grant_%0d started=%0b addr=%h wr=%0b, want 1 %h 0",
                         k, ok, mem_addr, mem_wr_en, want_addr);
            end
            step();
            mem_data_in = pat;
            mem_data_valid = 1'b1;
            step();
            mem_data_valid = 1'b0;
            if (k % 2 == 0) begin
                exp_ic = pat;
            end else begin
                exp_dc = pat;
            end
            checks++;
            if (ic_valid !== (k % 2 == 0) || dc_valid !== (k % 2 == 1) ||
                ic_data !== exp_ic || dc_rdata !== exp_dc) begin
                errors++;
                $display("FAIL done_%0d iv=%0b dv=%0b ic=%h dc=%h, want ic=%h dc=%h",
                         k, ic_valid, dc_valid, ic_data[31:0], dc_rdata[31:0],
                         exp_ic[31:0], exp_dc[31:0]);
            end
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        step();
    endtask

    task automatic test_write();
        logic [BLOCKSZ-1:0] pb = {8{64'hBEEF_0000_1234_5678}};
        bit ok;
        dc_addr = 64'h3000_0000;
        dc_wdata = pb;
        dc_wr = 1'b1;
        dc_req = 1'b1;
        wait_start(ok);
        checks++;
        if (!ok || mem_wr_en !== 1'b1 || mem_wdata !== pb || mem_addr !== 64'h3000_0000) begin
            errors++;
            $display("FAIL wr_issue started=%0b wr=%0b addr=%h, want 1 1 3000_0000",
                     ok, mem_wr_en, mem_addr);
        end
        step();
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wdata !== pb || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_wait wr=%0b wdata_ok=%0b busy=%0b, want 1 1 1",
                     mem_wr_en, mem_wdata === pb, busy);
        end
        mem_data_in = {16{32'h5555_AAAA}};
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        dc_req = 1'b0;
        dc_wr = 1'b0;
        checks++;
        if (dc_valid !== 1'b1 || dc_err !== 1'b0 || ic_valid !== 1'b0 || dc_rdata !== exp_dc) begin
            errors++;
            $display("FAIL wr_done dv=%0b de=%0b iv=%0b rdata=%h, want 1 0 0 %h",
                     dc_valid, dc_err, ic_valid, dc_rdata[31:0], exp_dc[31:0]);
        end
        step();
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wdata !== pb || dc_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle_hold wr=%0b wdata_ok=%0b dv=%0b busy=%0b, want 1 1 0 0",
                     mem_wr_en, mem_wdata === pb, dc_valid, busy);
        end
    endtask

    task automatic test_timeout();
        logic [BLOCKSZ-1:0] pe = {16{32'hE0E0_7777}};
        bit ok;
        ic_addr = 64'h4000_0000;
        ic_req = 1'b1;
        wait_start(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_start started=%0b, want 1", ok);
        end
        repeat (TIMEOUT) step();
        checks++;
        if (ic_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early iv=%0b busy=%0b at S+16, want 0 1", ic_valid, busy);
        end
        step();
        ic_req = 1'b0;
        checks++;
        if (ic_valid !== 1'b1 || ic_err !== 1'b1 || dc_valid !== 1'b0 || dc_err !== 1'b0 ||
            ic_data !== exp_ic) begin
            errors++;
            $display("FAIL to_done iv=%0b ie=%0b dv=%0b de=%0b ic=%h, want 1 1 0 0 %h",
                     ic_valid, ic_err, dc_valid, dc_err, ic_data[31:0], exp_ic[31:0]);
        end
        step();
        mem_data_in = {16{32'hDEAD_D0D0}};
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        checks++;
        if (ic_valid !== 1'b0 || dc_valid !== 1'b0 || busy !== 1'b0 || ic_data !== exp_ic) begin
            errors++;
            $display("FAIL to_stray iv=%0b dv=%0b busy=%0b ic=%h, want 0 0 0 %h",
                     ic_valid, dc_valid, busy, ic_data[31:0], exp_ic[31:0]);
        end
        ic_addr = 64'h5000_0010;
        ic_req = 1'b1;
        wait_start(ok);
        checks++;
        if (!ok || mem_addr !== 64'h5000_0000) begin
            errors++;
            $display("FAIL to_next_issue started=%0b addr=%h, want 1 5000_0000", ok, mem_addr);
        end
        step();
        mem_data_in = pe;
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        ic_req = 1'b0;
        checks++;
        if (ic_valid !== 1'b1 || ic_err !== 1'b0 || ic_data !== pe) begin
            errors++;
            $display("FAIL to_next_done iv=%0b ie=%0b ic=%h, want 1 0 %h",
                     ic_valid, ic_err, ic_data[31:0], pe[31:0]);
        end
        exp_ic = pe;
        step();
    endtask

    task automatic test_reset_mid();
        logic [BLOCKSZ-1:0] pf = {16{32'hF00D_0F0F}};
        int i0, d0;
        bit ok;
        ic_addr = 64'h7000_0000;
        ic_req = 1'b1;
        wait_start(ok);
        step();
        rst = 1'b0;
        ic_req = 1'b0;
        #1;
        i0 = ic_vcnt; d0 = dc_vcnt;
        checks++;
        if (!ok || busy !== 1'b0 || mem_addr !== '0 || mem_start_req !== 1'b0 ||
            ic_data !== '0 || dc_rdata !== '0 || ic_valid !== 1'b0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL mid_reset started=%0b busy=%0b addr=%h ic=%h dc=%h, want 1 0 0 0 0",
                     ok, busy, mem_addr, ic_data[31:0], dc_rdata[31:0]);
        end
        exp_ic = '0;
        exp_dc = '0;
        step();
        step();
        rst = 1'b1;
        dc_addr = 64'h6000_0040;
        dc_wr = 1'b0;
        dc_req = 1'b1;
        step();
        checks++;
        if (mem_start_req !== 1'b1 || mem_addr !== 64'h6000_0040 || ic_vcnt != i0 ||
            dc_vcnt != d0) begin
            errors++;
            $display("FAIL mid_restart start=%0b addr=%h ivalids=%0d, want 1 6000_0040 0",
                     mem_start_req, mem_addr, ic_vcnt - i0);
        end
        step();
        mem_data_in = pf;
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        dc_req = 1'b0;
        checks++;
        if (dc_valid !== 1'b1 || dc_err !== 1'b0 || dc_rdata !== pf) begin
            errors++;
            $display("FAIL mid_done dv=%0b de=%0b dc=%h, want 1 0 %h",
                     dc_valid, dc_err, dc_rdata[31:0], pf[31:0]);
        end
        exp_dc = pf;
        step();
    endtask

    task automatic test_idle_mdv();
        mem_data_in = {16{32'h0BAD_0BAD}};
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || ic_valid !== 1'b0 || dc_valid !== 1'b0 || mem_start_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_mdv busy=%0b iv=%0b dv=%0b start=%0b, want 0 0 0 0",
                     busy, ic_valid, dc_valid, mem_start_req);
        end
        step();
        checks++;
        if (busy !== 1'b0 || ic_data !== exp_ic || dc_rdata !== exp_dc || dc_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_mdv_hold busy=%0b ic=%h dc=%h, want 0 %h %h",
                     busy, ic_data[31:0], dc_rdata[31:0], exp_ic[31:0], exp_dc[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_contention();
        test_write();
        test_timeout();
        test_reset_mid();
        test_idle_mdv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish, want finish before 200us");
        $fatal(1);
    end

endmodule
